regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_pend_tracker.sv | 63 ++++++
 rtl/regfile_sb.sv | 89 ++++++++
 tb/tb_regfile_sb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the scoreboarded register file: architectural register
// indices and the default reset values of the global and stack pointers.
package rf_pkg;

  localparam int          ZERO_IDX    = 0;
  localparam int          GP_IDX      = 28;
  localparam int          SP_IDX      = 29;
  localparam logic [31:0] GP_INIT_DEF = 32'h0000_1800;
  localparam logic [31:0] SP_INIT_DEF = 32'h0000_2ffe;

endpackage : rf_pkg

// File: rtl/rf_pend_tracker.sv
// Scoreboard for the register file: one pending bit per register, a running
// count of pending registers, and a sticky double-issue error flag.
module rf_pend_tracker import rf_pkg::*; #(
  parameter int NREG   = 32,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  input  logic          wr_acc,
  input  logic [AW-1:0] wa,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          busy1,
  output logic          busy2,
  output logic [AW:0]   pend_cnt,
  output logic          err_dbl
);

  logic [NREG-1:0] pend_q, pend_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            iss_acc, set_new, clr_old, same_addr;

  always_comb begin
    iss_acc   = iss_en && (iss_addr != AW'(ZERO_IDX)) && !rst;
    same_addr = wr_acc && iss_acc && (wa == iss_addr);
    set_new   = iss_acc && !pend_q[iss_addr];
    // A clear that coincides with a set on the same register is cancelled:
    // the new producer keeps the bit alive.
    clr_old   = wr_acc && pend_q[wa] && !same_addr;

    pend_d = pend_q;
    if (wr_acc)  pend_d[wa]       = 1'b0;
    if (iss_acc) pend_d[iss_addr] = 1'b1;

    cnt_d = cnt_q + (AW+1)'(set_new) - (AW+1)'(clr_old);
    err_d = err_q || (iss_acc && pend_q[iss_addr] && !same_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    busy1 = (ra1 != AW'(ZERO_IDX)) && pend_q[ra1] && !(BYPASS && wr_acc && (wa == ra1));
    busy2 = (ra2 != AW'(ZERO_IDX)) && pend_q[ra2] && !(BYPASS && wr_acc && (wa == ra2));
  end

  assign pend_cnt = cnt_q;
  assign err_dbl  = err_q;

endmodule : rf_pend_tracker

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with optional write-to-read forwarding,
// a registered write acknowledge and a pending-producer scoreboard.
module regfile_sb import rf_pkg::*; #(
  parameter int            DW      = 32,
  parameter int            NREG    = 32,
  parameter logic [DW-1:0] GP_INIT = DW'(GP_INIT_DEF),
  parameter logic [DW-1:0] SP_INIT = DW'(SP_INIT_DEF),
  parameter bit            BYPASS  = 1'b1,
  localparam int           AW      = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  output logic          busy1,
  output logic          busy2,
  output logic          stall,
  output logic [AW:0]   pend_cnt,
  output logic          wr_ack,
  output logic          err_dbl
);

  logic [DW-1:0] data_q [NREG];
  logic [DW-1:0] data_d [NREG];
  logic          wr_ack_q, wr_ack_d;
  logic          wr_acc;

  assign wr_acc = we && (wa != AW'(ZERO_IDX)) && !rst;

  always_comb begin
    data_d = data_q;
    if (wr_acc) data_d[wa] = wd;
    wr_ack_d = wr_acc;
  end

  // NOTE: the storage array is reset explicitly because the pointer registers
  // need non-zero values; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) data_q[i] <= '0;
      data_q[GP_IDX] <= GP_INIT;
      data_q[SP_IDX] <= SP_INIT;
      wr_ack_q       <= 1'b0;
    end else begin
      data_q   <= data_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  // wr_acc is already gated by rst, so forwarding is suppressed during reset.
  always_comb begin
    if (ra1 == AW'(ZERO_IDX))               rd1 = '0;
    else if (BYPASS && wr_acc && wa == ra1) rd1 = wd;
    else                                    rd1 = data_q[ra1];

    if (ra2 == AW'(ZERO_IDX))               rd2 = '0;
    else if (BYPASS && wr_acc && wa == ra2) rd2 = wd;
    else                                    rd2 = data_q[ra2];
  end

  rf_pend_tracker #(
    .NREG   (NREG),
    .BYPASS (BYPASS)
  ) u_pend (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_acc   (wr_acc),
    .wa       (wa),
    .ra1      (ra1),
    .ra2      (ra2),
    .busy1    (busy1),
    .busy2    (busy2),
    .pend_cnt (pend_cnt),
    .err_dbl  (err_dbl)
  );

  assign stall  = busy1 | busy2;
  assign wr_ack = wr_ack_q;

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by random
// traffic, all compared against an array-based model of the register file.
module tb_regfile_sb;

  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam bit BYP  = 1'b1;

  logic          clk;
  logic          rst;
  logic [AW-1:0] ra1, ra2, wa, iss_addr;
  logic [DW-1:0] wd;
  logic          we, iss_en;
  logic [DW-1:0] rd1, rd2;
  logic          busy1, busy2, stall, wr_ack, err_dbl;
  logic [AW:0]   pend_cnt;

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] m_data [NREG];
  bit            m_pend [NREG];
  bit            m_ack;
  bit            m_err;

  regfile_sb #(
    .DW      (DW),
    .NREG    (NREG),
    .GP_INIT (32'h0000_1800),
    .SP_INIT (32'h0000_2ffe),
    .BYPASS  (BYP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy1    (busy1),
    .busy2    (busy2),
    .stall    (stall),
    .pend_cnt (pend_cnt),
    .wr_ack   (wr_ack),
    .err_dbl  (err_dbl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_data[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_data[28] = 32'h0000_1800;
    m_data[29] = 32'h0000_2ffe;
    m_ack = 1'b0;
    m_err = 1'b0;
  endtask

  // Applies the architectural effect of one rising edge with the current inputs.
  task automatic model_edge();
    bit wr, iss;
    if (rst) begin
      model_reset();
    end else begin
      wr  = we && (wa != 0);
      iss = iss_en && (iss_addr != 0);
      if (iss && m_pend[iss_addr] && !(wr && wa == iss_addr)) m_err = 1'b1;
      if (wr) begin
        m_data[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (iss) m_pend[iss_addr] = 1'b1;
      m_ack = wr;
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
    if (ra == 0) return '0;
    if (BYP && !rst && we && wa == ra) return wd;
    return m_data[ra];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] ra);
    if (ra == 0) return 1'b0;
    return m_pend[ra] && !(BYP && !rst && we && wa == ra);
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".rd1"},   64'(rd1),      64'(exp_rd(ra1)));
    check({tag, ".rd2"},   64'(rd2),      64'(exp_rd(ra2)));
    check({tag, ".busy1"}, 64'(busy1),    64'(exp_busy(ra1)));
    check({tag, ".busy2"}, 64'(busy2),    64'(exp_busy(ra2)));
    check({tag, ".stall"}, 64'(stall),    64'(exp_busy(ra1) | exp_busy(ra2)));
    check({tag, ".cnt"},   64'(pend_cnt), 64'(exp_cnt()));
    check({tag, ".ack"},   64'(wr_ack),   64'(m_ack));
    check({tag, ".err"},   64'(err_dbl),  64'(m_err));
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; wa = '0; wd = '0; iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    ra1 = '0; ra2 = '0;
    model_reset();

    // Reset, then read the pointer registers.
    rst = 1'b1;
    advance();
    idle();
    ra1 = 5'd28; ra2 = 5'd29;
    settle();
    check("r036_rd1", 64'(rd1), 64'h1800);
    check("r036_rd2", 64'(rd2), 64'h2ffe);
    check("r036_cnt", 64'(pend_cnt), 64'd0);
    check_all("r036");
    advance();

    // Write with same-cycle forwarding.
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra1 = 5'd5;
    settle();
    check("r037_byp", 64'(rd1), 64'hDEAD_BEEF);
    check_all("r037a");
    advance();
    idle();
    settle();
    check("r037_ack", 64'(wr_ack), 64'd1);
    check("r037_rd1", 64'(rd1), 64'hDEAD_BEEF);
    check_all("r037b");
    advance();

    // Writes and issues to r0 are ignored.
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; iss_en = 1'b1; iss_addr = 5'd0; ra1 = 5'd0;
    settle();
    check("r038_rd0", 64'(rd1), 64'd0);
    check_all("r038a");
    advance();
    idle();
    settle();
    check("r038_ack", 64'(wr_ack), 64'd0);
    check("r038_cnt", 64'(pend_cnt), 64'd0);
    check_all("r038b");
    advance();

    // Issue r7, observe busy, clear it with a write.
    iss_en = 1'b1; iss_addr = 5'd7; ra1 = 5'd7; ra2 = 5'd28;
    settle();
    check_all("r039a");
    advance();
    idle();
    settle();
    check("r039_busy", 64'(busy1), 64'd1);
    check("r039_stall", 64'(stall), 64'd1);
    check("r039_cnt1", 64'(pend_cnt), 64'd1);
    check_all("r039b");
    advance();
    we = 1'b1; wa = 5'd7; wd = 32'h1234_5678;
    settle();
    check("r039_byp_busy", 64'(busy1), 64'd0);
    check_all("r039c");
    advance();
    idle();
    settle();
    check("r039_cnt0", 64'(pend_cnt), 64'd0);
    check_all("r039d");
    advance();

    // Same-cycle issue + write on a pending register, then a true double issue.
    iss_en = 1'b1; iss_addr = 5'd9; ra1 = 5'd9;
    settle();
    advance();
    iss_en = 1'b1; iss_addr = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h0000_0099;
    settle();
    check_all("r040a");
    advance();
    idle();
    settle();
    check("r040_cnt", 64'(pend_cnt), 64'd1);
    check("r040_busy", 64'(busy1), 64'd1);
    check("r040_noerr", 64'(err_dbl), 64'd0);
    check("r040_data", 64'(rd1), 64'h99);
    check_all("r040b");
    iss_en = 1'b1; iss_addr = 5'd9;
    advance();
    idle();
    settle();
    check("r040_err", 64'(err_dbl), 64'd1);
    advance();
    settle();
    check("r040_sticky", 64'(err_dbl), 64'd1);
    check_all("r040c");
    advance();

    // Reset mid-operation with a write in flight.
    iss_en = 1'b1; iss_addr = 5'd3;
    advance();
    iss_en = 1'b1; iss_addr = 5'd4;
    advance();
    idle();
    rst = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'hCAFE_F00D; iss_en = 1'b1; iss_addr = 5'd6;
    ra1 = 5'd3; ra2 = 5'd4;
    settle();
    check("r041_nobyp", 64'(rd1), 64'd0);
    advance();
    idle();
    settle();
    check("r041_cnt", 64'(pend_cnt), 64'd0);
    check("r041_rd3", 64'(rd1), 64'd0);
    check("r041_ack", 64'(wr_ack), 64'd0);
    check("r041_err", 64'(err_dbl), 64'd0);
    check_all("r041");
    advance();

    // Random traffic over a narrow address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      we       = $urandom_range(0, 1) == 1;
      wa       = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 12));
      wd       = $urandom;
      iss_en   = $urandom_range(0, 2) == 0;
      iss_addr = ($urandom_range(0, 9) == 0) ? 5'd0 : AW'($urandom_range(1, 12));
      ra1      = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
      ra2      = ($urandom_range(0, 3) == 0) ? ra1 : AW'($urandom_range(0, 13));
      settle();
      check_all($sformatf("rnd%0d", n));
      advance();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_regfile_sb
